// File: rtl/i2c_pkg.sv
// Shared constants, bus state encoding and counter width helper for the I2C bus
// condition detector.
package i2c_pkg;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned FILTER_LEN_DEF     = 3;
  localparam int unsigned TBUF_CYCLES_DEF    = 64;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_t;

  // Bits needed for a counter that must be able to hold the value 'limit'.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Synchroniser chain followed by a persistence filter: a new level is accepted
// only after it has been seen for FILTER_LEN consecutive cycles.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = cnt_width(FILTER_LEN);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign dout     = r_level;

  // Idle bus level is high, so everything resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '1;
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      if (w_synced == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= w_synced;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_condition_detect.sv
// Filters SDA/SCL and reports START, repeated START, STOP, SCL edges, bus
// busy/free status and SCL-stuck-low timeout.
module i2c_bus_condition_detect
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF,
  parameter int unsigned TBUF_CYCLES    = TBUF_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sda_in,
  input  logic scl_in,
  output logic sda_f,
  output logic scl_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic bus_busy,
  output logic bus_free,
  output logic timeout
);

  localparam int unsigned IW = cnt_width(TBUF_CYCLES);
  localparam int unsigned LW = cnt_width(TIMEOUT_CYCLES);

  logic          w_sda_f;
  logic          w_scl_f;
  logic          r_sda_d;
  logic          r_scl_d;
  bus_state_t    r_state;
  bus_state_t    w_state_next;
  logic [IW-1:0] r_idle_cnt;
  logic [IW-1:0] w_idle_next;
  logic [LW-1:0] r_low_cnt;
  logic [LW-1:0] w_low_next;
  logic          w_start;
  logic          w_stop;
  logic          w_low_hit;
  logic          r_scl_rise;
  logic          r_scl_fall;
  logic          r_start_det;
  logic          r_rstart_det;
  logic          r_stop_det;
  logic          r_bus_free;
  logic          r_timeout;

  i2c_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sda_filt (
    .clk (clk),
    .rst (rst),
    .din (sda_in),
    .dout(w_sda_f)
  );

  i2c_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_scl_filt (
    .clk (clk),
    .rst (rst),
    .din (scl_in),
    .dout(w_scl_f)
  );

  // SCL must be high both before and after the SDA edge; a simultaneous edge is ignored.
  assign w_start = r_sda_d & ~w_sda_f & r_scl_d & w_scl_f;
  assign w_stop  = ~r_sda_d & w_sda_f & r_scl_d & w_scl_f;

  always_comb begin
    w_state_next = r_state;
    w_idle_next  = '0;
    w_low_next   = '0;
    w_low_hit    = 1'b0;

    case (r_state)
      BUS_IDLE: if (w_start) w_state_next = BUS_BUSY;
      BUS_BUSY: begin
        if (w_start) begin
          w_state_next = BUS_BUSY;
        end else if (w_stop || w_low_hit_c()) begin
          w_state_next = BUS_IDLE;
        end
      end
      default: w_state_next = BUS_IDLE;
    endcase

    if (w_scl_f && w_sda_f && (r_state == BUS_IDLE)) begin
      w_idle_next = (r_idle_cnt == IW'(TBUF_CYCLES)) ? r_idle_cnt : r_idle_cnt + IW'(1);
    end

    // Saturates at the limit so the timeout fires once per low period.
    if (!w_scl_f) begin
      w_low_hit  = (r_low_cnt == LW'(TIMEOUT_CYCLES - 1));
      w_low_next = (r_low_cnt == LW'(TIMEOUT_CYCLES)) ? r_low_cnt : r_low_cnt + LW'(1);
    end
  end

  function automatic logic w_low_hit_c();
    return !w_scl_f && (r_low_cnt == LW'(TIMEOUT_CYCLES - 1));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= BUS_IDLE;
      r_sda_d      <= 1'b1;
      r_scl_d      <= 1'b1;
      r_idle_cnt   <= '0;
      r_low_cnt    <= '0;
      r_scl_rise   <= 1'b0;
      r_scl_fall   <= 1'b0;
      r_start_det  <= 1'b0;
      r_rstart_det <= 1'b0;
      r_stop_det   <= 1'b0;
      r_bus_free   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sda_d      <= w_sda_f;
      r_scl_d      <= w_scl_f;
      r_idle_cnt   <= w_idle_next;
      r_low_cnt    <= w_low_next;
      r_scl_rise   <= ~r_scl_d & w_scl_f;
      r_scl_fall   <= r_scl_d & ~w_scl_f;
      r_start_det  <= w_start & (r_state == BUS_IDLE);
      r_rstart_det <= w_start & (r_state == BUS_BUSY);
      r_stop_det   <= w_stop;
      r_bus_free   <= (w_idle_next == IW'(TBUF_CYCLES)) & ~w_start;
      r_timeout    <= w_low_hit;
    end
  end

  assign sda_f      = w_sda_f;
  assign scl_f      = w_scl_f;
  assign scl_rise   = r_scl_rise;
  assign scl_fall   = r_scl_fall;
  assign start_det  = r_start_det;
  assign rstart_det = r_rstart_det;
  assign stop_det   = r_stop_det;
  assign bus_busy   = (r_state == BUS_BUSY);
  assign bus_free   = r_bus_free;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_i2c_bus_condition_detect.sv
// Randomised and directed bench for i2c_bus_condition_detect: a pin-history reference
// model queues the expected outputs for every cycle and a monitor compares them.
module tb_i2c_bus_condition_detect;

  localparam int SYNC = 2;
  localparam int FL   = 3;
  localparam int TB   = 64;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sda_in = 1'b1;
  logic scl_in = 1'b1;
  logic sda_f, scl_f, scl_rise, scl_fall, start_det, rstart_det, stop_det;
  logic bus_busy, bus_free, timeout;

  always #5 clk = ~clk;

  i2c_bus_condition_detect #(
    .SYNC_STAGES   (SYNC),
    .FILTER_LEN    (FL),
    .TBUF_CYCLES   (TB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sda_in    (sda_in),
    .scl_in    (scl_in),
    .sda_f     (sda_f),
    .scl_f     (scl_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .rstart_det(rstart_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy),
    .bus_free  (bus_free),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic sda_f, scl_f, scl_rise, scl_fall, start_det, rstart_det, stop_det;
    logic bus_busy, bus_free, timeout;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  int   n_start = 0, n_rstart = 0, n_stop = 0, n_rise = 0, n_fall = 0, n_tout = 0;

  // ---------------- reference model ----------------
  bit sda_hist[$];
  bit scl_hist[$];
  bit m_sda = 1, m_scl = 1, m_sda_prev = 1, m_scl_prev = 1;
  bit m_busy = 0;
  int idle_run = 0;
  int low_run = 0;
  bit cur_sda = 1, cur_scl = 1;

  function automatic bit hist_at(input bit is_sda, input int idx);
    if (idx < 0) return 1'b1;
    return is_sda ? sda_hist[idx] : scl_hist[idx];
  endfunction

  // A level flips once the pin, seen SYNC cycles late, has disagreed for FL cycles running.
  function automatic bit filt_next(input bit is_sda, input bit cur);
    int n = is_sda ? sda_hist.size() : scl_hist.size();
    bit all_differ = 1'b1;
    for (int k = 0; k < FL; k++)
      if (hist_at(is_sda, n - 1 - SYNC - k) == cur) all_differ = 1'b0;
    return all_differ ? !cur : cur;
  endfunction

  task automatic model_step(input bit p_sda, input bit p_scl, input bit p_rst);
    obs_t e;
    bit ns, nc, st, sp, hit;
    e = '0;
    if (p_rst) begin
      sda_hist.delete();
      scl_hist.delete();
      m_sda = 1; m_scl = 1; m_sda_prev = 1; m_scl_prev = 1;
      m_busy = 0; idle_run = 0; low_run = 0;
      e.sda_f = 1'b1;
      e.scl_f = 1'b1;
    end else begin
      sda_hist.push_back(p_sda);
      scl_hist.push_back(p_scl);
      ns  = filt_next(1'b1, m_sda);
      nc  = filt_next(1'b0, m_scl);
      st  = m_sda_prev && !m_sda && m_scl_prev && m_scl;
      sp  = !m_sda_prev && m_sda && m_scl_prev && m_scl;
      hit = 1'b0;
      if (!m_scl) begin
        if (low_run == TO - 1) hit = 1'b1;
        if (low_run < TO) low_run++;
      end else begin
        low_run = 0;
      end
      if (m_scl && m_sda && !m_busy) begin
        if (idle_run < TB) idle_run++;
      end else begin
        idle_run = 0;
      end
      e.sda_f      = ns;
      e.scl_f      = nc;
      e.scl_rise   = !m_scl_prev && m_scl;
      e.scl_fall   = m_scl_prev && !m_scl;
      e.start_det  = st && !m_busy;
      e.rstart_det = st && m_busy;
      e.stop_det   = sp;
      e.timeout    = hit;
      e.bus_free   = (idle_run == TB);
      if (st) m_busy = 1'b1;
      else if (sp || hit) m_busy = 1'b0;
      e.bus_busy = m_busy;
      m_sda_prev = m_sda; m_sda = ns;
      m_scl_prev = m_scl; m_scl = nc;
    end
    exp_q.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input bit sd, input bit sc, input bit r);
    @(negedge clk);
    sda_in  = sd;
    scl_in  = sc;
    rst     = r;
    cur_sda = sd;
    cur_scl = sc;
    model_step(sd, sc, r);
  endtask

  task automatic hold(input bit sd, input bit sc, input int n);
    repeat (n) cyc(sd, sc, 1'b0);
  endtask

  task automatic i2c_start();
    hold(1'b1, 1'b1, 8);
    hold(1'b0, 1'b1, 8);
  endtask

  task automatic i2c_rstart();
    hold(cur_sda, 1'b0, 5);
    hold(1'b1, 1'b0, 5);
    hold(1'b1, 1'b1, 8);
    hold(1'b0, 1'b1, 8);
  endtask

  task automatic i2c_bit(input bit b);
    hold(cur_sda, 1'b0, 5);
    hold(b, 1'b0, 5);
    hold(b, 1'b1, 8);
  endtask

  task automatic i2c_stop();
    hold(cur_sda, 1'b0, 5);
    hold(1'b0, 1'b0, 5);
    hold(1'b0, 1'b1, 8);
    hold(1'b1, 1'b1, 8);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc_n, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      n_start  += int'(start_det === 1'b1);
      n_rstart += int'(rstart_det === 1'b1);
      n_stop   += int'(stop_det === 1'b1);
      n_rise   += int'(scl_rise === 1'b1);
      n_fall   += int'(scl_fall === 1'b1);
      n_tout   += int'(timeout === 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sda_f", sda_f, e.sda_f);
        chk("scl_f", scl_f, e.scl_f);
        chk("scl_rise", scl_rise, e.scl_rise);
        chk("scl_fall", scl_fall, e.scl_fall);
        chk("start_det", start_det, e.start_det);
        chk("rstart_det", rstart_det, e.rstart_det);
        chk("stop_det", stop_det, e.stop_det);
        chk("bus_busy", bus_busy, e.bus_busy);
        chk("bus_free", bus_free, e.bus_free);
        chk("timeout", timeout, e.timeout);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scenarios ----------------
  initial begin
    int s0, r0, p0, ri0, f0, t0, nb, g;
    bit bs, bc;

    repeat (4) cyc(1'b1, 1'b1, 1'b1);
    hold(1'b1, 1'b1, 80);

    // short SDA glitch while SCL high
    s0 = n_start;
    hold(1'b0, 1'b1, 2);
    hold(1'b1, 1'b1, 20);
    chk_cnt("glitch_no_start", n_start - s0, 0);

    // START, 8 data bits + ACK, STOP
    s0 = n_start; p0 = n_stop; ri0 = n_rise;
    i2c_start();
    for (int i = 0; i < 8; i++) i2c_bit(1'($urandom_range(0, 1)));
    i2c_bit(1'b0);
    hold(1'b1, 1'b1, 80);
    chk_cnt("xfer_start", n_start - s0, 1);
    chk_cnt("xfer_stop", n_stop - p0, 1);
    chk_cnt("xfer_rises", n_rise - ri0, 9);

    // repeated START
    s0 = n_start; r0 = n_rstart;
    i2c_start();
    repeat (3) i2c_bit(1'($urandom_range(0, 1)));
    i2c_rstart();
    repeat (2) i2c_bit(1'($urandom_range(0, 1)));
    i2c_stop();
    hold(1'b1, 1'b1, 20);
    chk_cnt("rstart_once", n_rstart - r0, 1);
    chk_cnt("rstart_start", n_start - s0, 1);

    // SCL stuck low mid-transfer
    t0 = n_tout;
    i2c_start();
    repeat (3) i2c_bit(1'($urandom_range(0, 1)));
    hold(cur_sda, 1'b0, 40);
    hold(cur_sda, 1'b1, 8);
    i2c_stop();
    hold(1'b1, 1'b1, 20);
    chk_cnt("timeout_once", n_tout - t0, 1);

    // SDA and SCL falling together, then rising together
    hold(1'b1, 1'b1, 80);
    s0 = n_start; f0 = n_fall; p0 = n_stop;
    hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b1, 20);
    chk_cnt("simul_fall", n_fall - f0, 1);
    chk_cnt("simul_no_start", n_start - s0, 0);
    chk_cnt("simul_no_stop", n_stop - p0, 0);

    // reset mid-transfer
    i2c_start();
    repeat (4) i2c_bit(1'($urandom_range(0, 1)));
    repeat (3) cyc(cur_sda, 1'b0, 1'b1);
    hold(1'b1, 1'b1, 80);

    // randomised mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          i2c_start();
          nb = $urandom_range(1, 9);
          repeat (nb) i2c_bit(1'($urandom_range(0, 1)));
          if ($urandom_range(0, 1) == 1) begin
            i2c_rstart();
            repeat (2) i2c_bit(1'($urandom_range(0, 1)));
          end
          i2c_stop();
          hold(1'b1, 1'b1, $urandom_range(10, 80));
        end
        1: repeat (12) hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 5));
        2: begin
          i2c_start();
          hold(cur_sda, 1'b0, $urandom_range(10, 30));
          hold(cur_sda, 1'b1, 8);
          i2c_stop();
        end
        3: begin
          bs = cur_sda; bc = cur_scl;
          g = $urandom_range(1, 2);
          if ($urandom_range(0, 1) == 1) hold(!bs, bc, g);
          else hold(bs, !bc, g);
          hold(bs, bc, 10);
        end
        4: begin
          g = $urandom_range(1, 3);
          repeat (g) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
          hold(1'b1, 1'b1, $urandom_range(5, 20));
        end
        default: hold(1'b1, 1'b1, $urandom_range(20, 90));
      endcase
    end

    hold(1'b1, 1'b1, 10);
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_bus_condition_detect.md
I2C_BUS_CONDITION_DETECT -- requirements
Module: i2c_bus_condition_detect

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2 (min 2): synchroniser depth per line.
REQ-002 SHALL have parameter FILTER_LEN, default 3 (min 1): consecutive clk cycles a new synchronised level must hold before acceptance.
REQ-003 SHALL have parameter TBUF_CYCLES, default 64 (min 1): idle cycles after STOP before bus_free asserts.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096 (min 2): consecutive SCL-low cycles that flag a stuck bus.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port sda_in  input  1  raw, asynchronous SDA.
REQ-008 SHALL have port scl_in  input  1  raw, asynchronous SCL.
REQ-009 SHALL have port sda_f  output  1  filtered SDA level.
REQ-010 SHALL have port scl_f  output  1  filtered SCL level.
REQ-011 SHALL have port scl_rise  output  1  one-cycle pulse on scl_f 0->1.
REQ-012 SHALL have port scl_fall  output  1  one-cycle pulse on scl_f 1->0.
REQ-013 SHALL have port start_det  output  1  one-cycle pulse, START while bus idle.
REQ-014 SHALL have port rstart_det  output  1  one-cycle pulse, START while bus busy (repeated start).
REQ-015 SHALL have port stop_det  output  1  one-cycle pulse, STOP.
REQ-016 SHALL have port bus_busy  output  1  level, between START and STOP/timeout.
REQ-017 SHALL have port bus_free  output  1  level, bus idle for at least TBUF_CYCLES.
REQ-018 SHALL have port timeout  output  1  one-cycle pulse, SCL held low TIMEOUT_CYCLES.

Function
REQ-019 Each line SHALL pass through SYNC_STAGES flops, then a filter: counter increments each cycle while synced value differs from filtered value; counter clears when they match.
REQ-020 When the counter reaches FILTER_LEN, the filtered value SHALL take the synced value and the counter SHALL clear; pulses shorter than FILTER_LEN cycles never reach the filtered output.
REQ-021 Latency SHALL be SYNC_STAGES+FILTER_LEN cycles from a stable pin change to the filtered change; all detect outputs SHALL be registered, 1 cycle later.
REQ-022 START SHALL be a sda_f 1->0 transition while scl_f is 1 in both the previous and current cycle; STOP SHALL be the same with sda_f 0->1.
REQ-023 If sda_f and scl_f change in the same cycle, no START/STOP SHALL be reported; scl_rise/scl_fall still pulse.
REQ-024 A START with bus_busy=0 SHALL pulse start_det; with bus_busy=1 it SHALL pulse rstart_det instead; the two are mutually exclusive.
REQ-025 bus_busy SHALL set on any START and clear on STOP or timeout; STOP while not busy SHALL still pulse stop_det.
REQ-026 The idle counter SHALL count cycles with scl_f=1, sda_f=1 and bus_busy=0, and clear otherwise; bus_free SHALL assert when it reaches TBUF_CYCLES, saturating there, and SHALL deassert in the cycle any START is detected.
REQ-027 The low counter SHALL count consecutive scl_f=0 cycles; on reaching TIMEOUT_CYCLES, timeout SHALL pulse once and bus_busy SHALL clear; the counter SHALL saturate with no further pulses until scl_f returns to 1.
REQ-028 Counter widths SHALL be $clog2(limit+1); no counter SHALL wrap.

Reset
REQ-029 While rst=1: sync flops, sda_f and scl_f SHALL be 1; all counters SHALL be 0; all pulses, bus_busy and bus_free SHALL be 0.
REQ-030 rst asserted mid-transaction SHALL abandon state; after release, bus_free SHALL require a full TBUF_CYCLES idle count.

Structure
REQ-031 Shared package i2c_pkg SHALL hold the default parameter constants and a $clog2-based width helper.
REQ-032 Sub-module i2c_glitch_filter (sync chain + filter, REQ-019/020) SHALL be instantiated once per line.

Verification
REQ-033 With FILTER_LEN=3, a 2-cycle SDA low glitch while SCL=1 -> sda_f unchanged, no start_det.
REQ-034 START, 9 SCL pulses, STOP (defaults) -> start_det at pin edge +6 cycles, 9 scl_rise, stop_det, bus_busy high in between, bus_free 64 cycles after STOP.
REQ-035 START, data, second START -> rstart_det=1, start_det=0, bus_busy stays 1.
REQ-036 TIMEOUT_CYCLES=16, SCL held low 40 cycles mid-transfer -> exactly one timeout pulse, bus_busy=0.
REQ-037 SDA and SCL both falling in the same cycle -> scl_fall only, no start_det.
REQ-038 rst pulsed during a transfer -> all outputs at reset values; after release, no bus_free before 64 idle cycles.
